// File: rtl/contador_pkg.sv
// Shared definitions for the shift/rotate counter sequencer: mode codes seen by
// the counter stage, sequencer FSM encoding and the counter width.
package contador_pkg;

    localparam int CNT_W = 7;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_LOAD   = 2'b10;
    localparam logic [1:0] MODE_ROTATE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/prescaler_passo.sv
// Step-pacing prescaler: counts 0..DIV_MAX-1 while enabled and flags the
// terminal count with a one-cycle tick.
module prescaler_passo #(
    parameter int DIV_WIDTH = 24,
    parameter int DIV_MAX   = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [DIV_WIDTH-1:0] TERM = DIV_WIDTH'(DIV_MAX - 1);

    logic [DIV_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == TERM) ? '0 : count + DIV_WIDTH'(1);
        end
    end

    assign tick = enable && (count == TERM);

endmodule

// File: rtl/controle_contador.sv
// Sequencer for the 7-bit shift/rotate counter: one parallel load, then a
// programmed number of prescaler-paced shift/rotate steps, then hold.
module controle_contador
    import contador_pkg::*;
#(
    parameter int DIV_WIDTH = 24,
    parameter int DIV_MAX   = 12_500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             rotate_sel,
    input  logic             fill,
    input  logic [CNT_W-1:0] load_value,
    input  logic [CNT_W-1:0] steps_cfg,
    output logic [CNT_W-1:0] bits,
    output logic             d,
    output logic             ch0,
    output logic             ch1,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] step_count,
    output state_t           state
);

    state_t           state_next;
    logic [CNT_W-1:0] cfg_load;
    logic [CNT_W-1:0] cfg_steps;
    logic             cfg_rotate;
    logic             cfg_fill;
    logic [1:0]       mode_q;
    logic [1:0]       mode_next;
    logic             d_next;
    logic             busy_next;
    logic             done_next;
    logic [CNT_W-1:0] count_next;
    logic             latch_cfg;
    logic             presc_clear;
    logic             tick;

    prescaler_passo #(
        .DIV_WIDTH(DIV_WIDTH),
        .DIV_MAX  (DIV_MAX)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (presc_clear),
        .enable(state == ST_RUN),
        .tick  (tick)
    );

    // Outputs are registered from the current state's decisions, so every
    // mode code reaches the counter one edge after the FSM chose it.
    always_comb begin
        state_next  = state;
        mode_next   = MODE_HOLD;
        d_next      = 1'b0;
        busy_next   = 1'b0;
        done_next   = 1'b0;
        count_next  = step_count;
        latch_cfg   = 1'b0;
        presc_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    latch_cfg   = 1'b1;
                    presc_clear = 1'b1;
                    count_next  = '0;
                    state_next  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mode_next  = MODE_LOAD;
                busy_next  = 1'b1;
                state_next = (cfg_steps == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else begin
                    busy_next = 1'b1;
                    if (tick) begin
                        mode_next  = cfg_rotate ? MODE_ROTATE : MODE_SHIFT;
                        d_next     = cfg_rotate ? 1'b0 : cfg_fill;
                        count_next = step_count + CNT_W'(1);
                        if (step_count + CNT_W'(1) == cfg_steps) begin
                            state_next = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cfg_load   <= '0;
            cfg_steps  <= '0;
            cfg_rotate <= 1'b0;
            cfg_fill   <= 1'b0;
            mode_q     <= MODE_HOLD;
            bits       <= '0;
            d          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_count <= '0;
        end else begin
            state      <= state_next;
            mode_q     <= mode_next;
            d          <= d_next;
            busy       <= busy_next;
            done       <= done_next;
            step_count <= count_next;
            if (latch_cfg) begin
                cfg_load   <= load_value;
                cfg_steps  <= steps_cfg;
                cfg_rotate <= rotate_sel;
                cfg_fill   <= fill;
            end
            if (state == ST_LOAD) begin
                bits <= cfg_load;
            end
        end
    end

    assign ch1 = mode_q[1];
    assign ch0 = mode_q[0];

endmodule

// File: tb/tb_controle_contador.sv
// Bench for controle_contador: expected counter-stage events are queued by the
// driver and matched by a monitor whenever a mode pulse or done appears.
module tb_controle_contador;
    import contador_pkg::*;

    localparam int DIV_MAX = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             rotate_sel = 1'b0;
    logic             fill = 1'b0;
    logic [CNT_W-1:0] load_value = '0;
    logic [CNT_W-1:0] steps_cfg = '0;
    logic [CNT_W-1:0] bits;
    logic             d;
    logic             ch0;
    logic             ch1;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] step_count;
    state_t           state;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_ev = 0;
    bit mon_en = 1'b0;
    logic [6:0] model = '0;
    // Event word: {gap since previous event, done, ch1, ch0, d, bits, step_count}
    logic [25:0] exp_q[$];

    controle_contador #(
        .DIV_WIDTH(8),
        .DIV_MAX  (DIV_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .rotate_sel(rotate_sel),
        .fill      (fill),
        .load_value(load_value),
        .steps_cfg (steps_cfg),
        .bits      (bits),
        .d         (d),
        .ch0       (ch0),
        .ch1       (ch1),
        .busy      (busy),
        .done      (done),
        .step_count(step_count),
        .state     (state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model of the downstream counter stage
    always @(posedge clk) begin
        case ({ch1, ch0})
            2'b10:   model <= bits;
            2'b01:   model <= {model[5:0], d};
            2'b11:   model <= {model[5:0], model[6]};
            default: model <= model;
        endcase
    end

    function automatic logic [25:0] ev(input int gap, input bit dn, input logic [1:0] ch,
                                       input bit dd, input logic [6:0] b, input logic [6:0] sc);
        ev = {8'(gap), dn, ch, dd, b, sc};
    endfunction

    task automatic chk(input string name, input logic [25:0] act, input logic [25:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input logic [6:0] lv, input logic rs, input logic fl, input logic [6:0] st);
        @(negedge clk);
        load_value = lv;
        rotate_sel = rs;
        fill       = fl;
        steps_cfg  = st;
        start      = 1'b1;
        last_ev    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_state"}, 26'(state), 26'(ST_IDLE));
        chk({tag, "_busy"}, 26'(busy), 26'(0));
        chk({tag, "_ch"}, 26'({ch1, ch0}), 26'(0));
    endtask

    // Monitor: any mode pulse or done must match the head of the expected queue
    initial begin
        logic [25:0] act;
        forever begin
            @(negedge clk);
            if (mon_en && (ch1 || ch0 || done)) begin
                act = {8'(cyc - last_ev), done, ch1, ch0, d, bits, step_count};
                last_ev = cyc;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got %h expected none (cycle %0d)", act, cyc);
                end else begin
                    chk("event", act, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        // 1. Reset after random activity
        wait_cycles(3);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start      = 1'($urandom_range(0, 1));
            stop       = 1'($urandom_range(0, 1));
            rotate_sel = 1'($urandom_range(0, 1));
            fill       = 1'($urandom_range(0, 1));
            load_value = 7'($urandom_range(0, 127));
            steps_cfg  = 7'($urandom_range(0, 3));
        end
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        wait_cycles(2);
        chk("rst_outputs", 26'({bits, d, ch1, ch0, busy, done, step_count}), 26'(0));
        chk("rst_state", 26'(state), 26'(ST_IDLE));
        rst = 1'b0;
        mon_en = 1'b1;

        // 2. Load only
        exp_q.push_back(ev(1, 0, MODE_LOAD, 0, 7'b1010101, 0));
        exp_q.push_back(ev(1, 1, MODE_HOLD, 0, 7'b1010101, 0));
        launch(7'b1010101, 0, 0, 0);
        @(negedge clk);
        chk("load_busy", 26'(busy), 26'(1));
        wait_cycles(4);
        check_idle("load");
        chk("load_count", 26'(step_count), 26'(0));
        chk("load_model", 26'(model), 26'(7'b1010101));
        chk("load_drain", 26'(exp_q.size()), 26'(0));

        // 3. Rotate, with config inputs disturbed mid-run
        exp_q.push_back(ev(1, 0, MODE_LOAD, 0, 7'b0000001, 0));
        for (int k = 1; k <= 3; k++) exp_q.push_back(ev(DIV_MAX, 0, MODE_ROTATE, 0, 7'b0000001, 7'(k)));
        exp_q.push_back(ev(1, 1, MODE_HOLD, 0, 7'b0000001, 3));
        launch(7'b0000001, 1, 0, 3);
        wait_cycles(3);
        load_value = 7'h7F;
        steps_cfg  = 7'd1;
        rotate_sel = 1'b0;
        fill       = 1'b1;
        start      = 1'b1;
        wait_cycles(4);
        start = 1'b0;
        wait_cycles(12);
        check_idle("rot");
        chk("rot_count", 26'(step_count), 26'(3));
        chk("rot_model", 26'(model), 26'(7'b0001000));
        chk("rot_drain", 26'(exp_q.size()), 26'(0));

        // 4. Shift with fill
        exp_q.push_back(ev(1, 0, MODE_LOAD, 0, 7'b0000000, 0));
        for (int k = 1; k <= 7; k++) exp_q.push_back(ev(DIV_MAX, 0, MODE_SHIFT, 1, 7'b0000000, 7'(k)));
        exp_q.push_back(ev(1, 1, MODE_HOLD, 0, 7'b0000000, 7));
        launch(7'b0000000, 0, 1, 7);
        wait_cycles(34);
        check_idle("shift");
        chk("shift_count", 26'(step_count), 26'(7));
        chk("shift_model", 26'(model), 26'(7'b1111111));
        chk("shift_drain", 26'(exp_q.size()), 26'(0));

        // 5. Abort after the second step
        exp_q.push_back(ev(1, 0, MODE_LOAD, 0, 7'b0110011, 0));
        exp_q.push_back(ev(DIV_MAX, 0, MODE_SHIFT, 0, 7'b0110011, 1));
        exp_q.push_back(ev(DIV_MAX, 0, MODE_SHIFT, 0, 7'b0110011, 2));
        launch(7'b0110011, 0, 0, 10);
        wait_cycles(9);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_idle("abort");
        chk("abort_count", 26'(step_count), 26'(2));
        wait_cycles(20);
        chk("abort_count_hold", 26'(step_count), 26'(2));
        chk("abort_model", 26'(model), 26'(7'b1001100));
        chk("abort_drain", 26'(exp_q.size()), 26'(0));

        // 6. Start and stop together: stays idle
        @(negedge clk);
        load_value = 7'h2A;
        steps_cfg  = 7'd2;
        start = 1'b1;
        stop  = 1'b1;
        wait_cycles(3);
        check_idle("startstop");
        start = 1'b0;
        stop  = 1'b0;
        wait_cycles(3);

        // 1b. Reset mid-run: no further pulses
        exp_q.push_back(ev(1, 0, MODE_LOAD, 0, 7'b0000001, 0));
        exp_q.push_back(ev(DIV_MAX, 0, MODE_ROTATE, 0, 7'b0000001, 1));
        launch(7'b0000001, 1, 0, 10);
        wait_cycles(6);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        chk("midrst_outputs", 26'({bits, d, ch1, ch0, busy, done, step_count}), 26'(0));
        chk("midrst_state", 26'(state), 26'(ST_IDLE));
        wait_cycles(20);
        chk("midrst_drain", 26'(exp_q.size()), 26'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_contador.md
Name: controle_contador

Overview:
Upstream sequencer for the 7-bit shift/rotate counter stage.
- Drives that stage's parallel-load bits, serial input d and mode select (ch1,ch0).
- Issues one load, then a programmed number of shift or rotate steps paced by an internal prescaler, then returns to hold.
- Sits between the board inputs (keys/switches) and the counter stage; both blocks run on the same clk.

Parameters:
DIV_WIDTH, 24, width of the prescaler counter.
DIV_MAX, 12_500_000, clk cycles per step (must be >= 1 and < 2**DIV_WIDTH); benches use 4.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  level; sampled in IDLE, launches a sequence.
stop  input  1  level; aborts a running sequence.
rotate_sel  input  1  0 = shift with serial fill, 1 = rotate (q6 -> q0); latched at start.
fill  input  1  serial fill value for shift mode; latched at start.
load_value  input  7  pattern loaded into the counter; latched at start.
steps_cfg  input  7  number of shift/rotate steps after load (0..127); latched at start.
bits  output  7  parallel-load value to the counter (bit0..bit6).
d  output  1  serial input to the counter.
ch0  output  1  mode select LSB.
ch1  output  1  mode select MSB.
busy  output  1  high in LOAD and RUN.
done  output  1  one-cycle pulse on normal completion.
step_count  output  7  steps issued in the current sequence.

Behaviour:
- Mode contract with the counter stage ({ch1,ch0}): 00 hold, 01 shift in d, 10 parallel load, 11 rotate. The counter acts on every clk edge, so any non-00 code lasts exactly one cycle.
- Reset (rst=1 at a clk edge) takes priority over everything, including mid-sequence:
  - state -> IDLE;
  - bits=0, d=0, {ch1,ch0}=00, busy=0, done=0, step_count=0;
  - prescaler cleared and all latched configuration cleared.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Outputs {ch1,ch0}=00.
  - If start=1 and stop=0: latch load_value, rotate_sel, fill and steps_cfg; clear step_count; go to LOAD.
  - If start and stop are both 1, stop wins and the FSM stays in IDLE.
- LOAD (exactly one cycle):
  - {ch1,ch0}=10, bits=latched load_value, busy=1.
  - Next state is RUN, or DONE if the latched steps_cfg = 0.
- RUN:
  - busy=1. The prescaler counts 0..DIV_MAX-1 and wraps to 0.
  - When the prescaler is at terminal count DIV_MAX-1:
    - {ch1,ch0} = 11 if rotate, else 01;
    - d = latched fill in shift mode, 0 in rotate mode;
    - step_count increments.
  - On every other RUN cycle, {ch1,ch0}=00.
  - The first step occurs DIV_MAX cycles after LOAD; consecutive steps are DIV_MAX cycles apart.
  - When the step that makes step_count equal the latched steps_cfg is issued, the next state is DONE.
  - stop=1 in RUN: next state is IDLE and {ch1,ch0}=00 that cycle. No step is issued even at terminal count. done stays 0, and step_count holds its last value.
  - start is ignored while busy.
- DONE (one cycle): done=1, busy=0, {ch1,ch0}=00, then IDLE. step_count holds until the next start.
- bits holds the latched load_value after LOAD. It only matters when ch=10.
- Latency: start sampled at edge N -> ch=10 visible after edge N+1 -> first step after edge N+1+DIV_MAX.
- Prescaler is cleared on entry to LOAD and is not advanced outside RUN.

Decomposition:
- Shared package (contador_pkg):
  - mode codes MODE_HOLD=2'b00, MODE_SHIFT=2'b01, MODE_LOAD=2'b10, MODE_ROTATE=2'b11;
  - FSM state encoding (IDLE, LOAD, RUN, DONE);
  - counter width constant CNT_W=7.
- One natural sub-module, prescaler_passo: a DIV_MAX/DIV_WIDTH-parameterised tick counter with clear and enable inputs, producing a one-cycle tick at terminal count.

Test Plan:
1. Reset: rst=1 for 2 cycles after random activity -> all outputs 0, state IDLE; repeat rst mid-RUN -> same, no further ch pulses.
2. Load only: load_value=7'b1010101, steps_cfg=0, start pulse -> one cycle ch=10 with bits=1010101, then done=1 next cycle, busy low, step_count=0.
3. Rotate: DIV_MAX=4, load_value=7'b0000001, rotate_sel=1, steps_cfg=3 -> ch=11 exactly 3 times, 4 cycles apart; counter model reads 0001000; done pulses once; step_count=3.
4. Shift with fill: fill=1, rotate_sel=0, load_value=0, steps_cfg=7 -> 7 ch=01 pulses with d=1; counter model reads 1111111; done=1.
5. Abort: steps_cfg=10, stop=1 after 2nd step -> no further steps, done never asserts, step_count=2, IDLE next cycle.
6. Simultaneous start+stop in IDLE -> no LOAD. Changing load_value/steps_cfg during RUN -> no effect on the sequence.
